// File: rtl/counter_chain_pkg.sv
// Shared types and default sizes for the two-level loop-nest sequencer.
package counter_chain_pkg;

    localparam int DEFAULT_WIDTH      = 6;
    localparam int DEFAULT_PERF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/counter_chain_sequencer_index_counter.sv
// Single wrap counter: counts 0..max on each enable and wraps back to 0.
// Instantiated once for the inner loop and once for the outer loop.
module index_counter
    import counter_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] idx,
    output logic             wrap
);

    // A wrap is an enabled step taken from the last index.
    assign wrap = en && (idx == max);

    // Clear has priority over counting; stepping from max returns to 0, never past it.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            idx <= '0;
        end else if (en) begin
            if (idx == max) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_chain_sequencer.sv
// Two-level (outer x inner) loop-nest sequencer with back-pressure.
// Optional stall-cycle counter: define COUNTER_CHAIN_SEQUENCER_PERF_EN.
module counter_chain_sequencer
    import counter_chain_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PERF_WIDTH = DEFAULT_PERF_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_input_start,
    input  logic                  io_input_abort,
    input  logic [WIDTH-1:0]      io_input_innerMax,
    input  logic [WIDTH-1:0]      io_input_outerMax,
    input  logic                  io_input_stall,
    output logic                  io_output_busy,
    output logic                  io_output_valid,
    output logic [WIDTH-1:0]      io_output_inner,
    output logic [WIDTH-1:0]      io_output_outer,
    output logic                  io_output_innerDone,
    output logic                  io_output_done
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] io_output_stallCycles
`endif
);

    // Saturating increment for the stall-cycle counter.
    function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
        if (v == {PERF_WIDTH{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    state_e           state;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;
    logic [WIDTH-1:0] inner_max_q;
    logic [WIDTH-1:0] outer_max_q;
    logic [WIDTH-1:0] inner_idx;
    logic [WIDTH-1:0] outer_idx;
    logic             inner_wrap;
    logic             outer_wrap;
    logic             accept;
    logic             start_ok;

    // A start is honoured only from IDLE and only when abort is not also asserted.
    assign start_ok = (state == IDLE) && io_input_start && !io_input_abort;
    // A pair is consumed when it is presented and the consumer is ready.
    assign accept   = valid_q && !io_input_stall;

    index_counter #(.WIDTH(WIDTH)) u_inner (
        .clock (clock),
        .reset (reset),
        .clr   (io_input_abort),
        .en    (accept),
        .max   (inner_max_q),
        .idx   (inner_idx),
        .wrap  (inner_wrap)
    );

    // The outer loop advances only when the inner loop wraps; its wrap marks the last pair.
    index_counter #(.WIDTH(WIDTH)) u_outer (
        .clock (clock),
        .reset (reset),
        .clr   (io_input_abort),
        .en    (inner_wrap),
        .max   (outer_max_q),
        .idx   (outer_idx),
        .wrap  (outer_wrap)
    );

    // Control FSM: latches bounds on start and registers busy/valid/done with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            inner_max_q <= '0;
            outer_max_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_ok) begin
                        state       <= RUN;
                        busy_q      <= 1'b1;
                        valid_q     <= 1'b1;
                        inner_max_q <= io_input_innerMax;
                        outer_max_q <= io_input_outerMax;
                    end
                end
                RUN: begin
                    if (io_input_abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (outer_wrap) begin
                        state   <= DONE;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io_output_busy      = busy_q;
    assign io_output_valid     = valid_q;
    assign io_output_done      = done_q;
    assign io_output_inner     = inner_idx;
    assign io_output_outer     = outer_idx;
    assign io_output_innerDone = inner_wrap;

`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt;

    // Counts presented-but-stalled cycles; cleared per run and held once the run ends.
    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            stall_cnt <= '0;
        end else if (valid_q && io_input_stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign io_output_stallCycles = stall_cnt;
`endif

endmodule

// File: tb/tb_counter_chain_sequencer.sv
// Directed scoreboard bench for counter_chain_sequencer.
module tb_counter_chain_sequencer;

    localparam int W  = 6;
    localparam int PW = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         stall = 1'b0;
    logic [W-1:0] inner_max = '0;
    logic [W-1:0] outer_max = '0;
    logic         busy;
    logic         valid;
    logic [W-1:0] inner;
    logic [W-1:0] outer;
    logic         inner_done;
    logic         done;
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
    logic [PW-1:0] stall_cycles;
`endif

    always #5 clock = ~clock;

    counter_chain_sequencer #(.WIDTH(W), .PERF_WIDTH(PW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_input_start        (start),
        .io_input_abort        (abort),
        .io_input_innerMax     (inner_max),
        .io_input_outerMax     (outer_max),
        .io_input_stall        (stall),
        .io_output_busy        (busy),
        .io_output_valid       (valid),
        .io_output_inner       (inner),
        .io_output_outer       (outer),
        .io_output_innerDone   (inner_done),
        .io_output_done        (done)
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
        ,
        .io_output_stallCycles (stall_cycles)
`endif
    );

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] o;
        logic         last_inner;
    } pair_t;

    pair_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected row-major pair order for a nest.
    task automatic push_nest(input int imax, input int omax);
        pair_t p;
        for (int o = 0; o <= omax; o++) begin
            for (int i = 0; i <= imax; i++) begin
                p.i          = i[W-1:0];
                p.o          = o[W-1:0];
                p.last_inner = (i == imax);
                exp_q.push_back(p);
            end
        end
    endtask

    // One full run from IDLE: optional stall burst on pair index stall_idx,
    // optional start re-pulse with changed bounds at cycle repulse_cyc.
    task automatic run_seq(input int imax, input int omax, input int stall_idx,
                           input int stall_len, input int repulse_cyc);
        int cyc;
        int acc;
        int stalled;
        int exp_done;
        int budget;
        bit done_seen;
        exp_q.delete();
        push_nest(imax, omax);
        exp_done  = 1 + (imax + 1) * (omax + 1) + stall_len;
        budget    = exp_done + 8;
        inner_max = imax[W-1:0];
        outer_max = omax[W-1:0];
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cyc       = 1;
        acc       = 0;
        stalled   = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc <= budget) begin
            if (cyc == repulse_cyc) begin
                start     = 1'b1;
                inner_max = inner_max ^ 6'h15;
                outer_max = outer_max ^ 6'h0a;
            end else begin
                start = 1'b0;
            end
            stall = (acc == stall_idx) && (stalled < stall_len);
            #1;
            if (exp_q.size() > 0) begin
                chk("run_valid", 32'(valid), 1);
                chk("run_busy", 32'(busy), 1);
                chk("run_done_low", 32'(done), 0);
                chk("run_inner", 32'(inner), 32'(exp_q[0].i));
                chk("run_outer", 32'(outer), 32'(exp_q[0].o));
                chk("run_innerDone", 32'(inner_done), 32'(exp_q[0].last_inner && !stall));
                if (!stall) begin
                    void'(exp_q.pop_front());
                    acc++;
                end else begin
                    stalled++;
                end
            end else begin
                chk("done_cycle", cyc, exp_done);
                chk("done_pulse", 32'(done), 1);
                chk("done_valid_low", 32'(valid), 0);
                chk("done_busy", 32'(busy), 1);
                done_seen = 1'b1;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("post_busy", 32'(busy), 0);
        chk("post_done", 32'(done), 0);
        chk("post_valid", 32'(valid), 0);
        chk("post_inner", 32'(inner), 0);
        chk("post_outer", 32'(outer), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_inner", 32'(inner), 0);
        chk("rst_outer", 32'(outer), 0);
        chk("rst_innerDone", 32'(inner_done), 0);
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
        chk("rst_stallCycles", 32'(stall_cycles), 0);
`endif
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // 1: 3x2 nest, no stalls
        run_seq(2, 1, -1, 0, -1);
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
        chk("t1_stallCycles", 32'(stall_cycles), 0);
`endif

        // 2: single pair
        run_seq(0, 0, -1, 0, -1);

        // 3: 4-cycle stall on (2,0)
        run_seq(3, 0, 2, 4, -1);
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
        chk("t3_stallCycles", 32'(stall_cycles), 4);
        tick();
        chk("t3_stallCycles_hold", 32'(stall_cycles), 4);
`endif

        // 4: abort at (1,1), then replay
        exp_q.delete();
        push_nest(2, 1);
        inner_max = 6'd2;
        outer_max = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ab_inner", 32'(inner), 32'(exp_q[0].i));
            chk("ab_outer", 32'(outer), 32'(exp_q[0].o));
            void'(exp_q.pop_front());
            tick();
        end
        chk("ab_at_inner", 32'(inner), 1);
        chk("ab_at_outer", 32'(outer), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_valid", 32'(valid), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_inner0", 32'(inner), 0);
        chk("ab_outer0", 32'(outer), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ab_no_done", 32'(done), 0);
        end
        run_seq(2, 1, -1, 0, -1);
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
        chk("t4_stallCycles_cleared", 32'(stall_cycles), 0);
`endif

        // 5: start re-pulsed mid-run with changed bounds
        run_seq(2, 1, -1, 0, 3);

        // Boundaries: stall on last pair, innerMax=0, full-range bounds
        run_seq(1, 1, 3, 2, -1);
        run_seq(0, 2, -1, 0, -1);
        run_seq(63, 63, -1, 0, -1);

        // 6: reset mid-run, then start&&abort in IDLE
        inner_max = 6'd3;
        outer_max = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(valid), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_inner", 32'(inner), 0);
        chk("mr_outer", 32'(outer), 0);
`ifdef COUNTER_CHAIN_SEQUENCER_PERF_EN
        chk("mr_stallCycles", 32'(stall_cycles), 0);
`endif
        tick();
        chk("mr_no_done", 32'(done), 0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_valid", 32'(valid), 0);
        tick();
        chk("sa_busy_later", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
